// File: rtl/seq_pkg.sv
// Shared definitions for the one-hot sequence generator/consumer path.
// State encoding of the sequence monitor and the default vector width.
package seq_pkg;

   localparam int SEQ_WIDTH = 16;

   typedef enum logic [1:0] {
      UNLOCKED = 2'd0,
      ACQUIRE  = 2'd1,
      LOCKED   = 2'd2
   } seq_state_t;

endpackage

// File: rtl/onehot_to_bin.sv
// One-hot to binary encoder with a legality flag (exactly one bit set).
// Purely combinational, no backpressure.
module onehot_to_bin
   import seq_pkg::*;
#(
   parameter int WIDTH = SEQ_WIDTH
) (
   input  logic [WIDTH-1:0]         vec,
   output logic [$clog2(WIDTH)-1:0] index,
   output logic                     legal
);

   localparam int CODE_W = $clog2(WIDTH);

   // OR of set-bit positions; only meaningful when legal is high.
   always_comb begin
      index = '0;
      for (int i = 0; i < WIDTH; i++) begin
         if (vec[i]) index = index | CODE_W'(i);
      end
   end

   assign legal = (vec != '0) && ((vec & (vec - WIDTH'(1))) == '0);

endmodule

// File: rtl/onehot_sequence_encoder.sv
// Re-encodes a one-hot stream to binary and checks it steps +1 (mod WIDTH).
// Latency 1 clk; no backpressure, samples whenever in_valid is high.
module onehot_sequence_encoder
   import seq_pkg::*;
#(
   parameter int WIDTH    = SEQ_WIDTH,
   parameter int LOCK_CNT = 3,
   parameter int ERR_W    = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     in_valid,
   input  logic [WIDTH-1:0]         onehot_in,
   input  logic                     clr_err,
   output logic [$clog2(WIDTH)-1:0] code,
   output logic                     code_valid,
   output logic                     onehot_err,
   output logic                     seq_err,
   output logic                     locked,
   output logic [ERR_W-1:0]         err_count
);

   localparam int CODE_W  = $clog2(WIDTH);
   localparam int MATCH_W = 4;

   seq_state_t          state;
   logic [MATCH_W-1:0]  match;
   logic [MATCH_W-1:0]  match_inc;
   logic [CODE_W-1:0]   index;
   logic [CODE_W-1:0]   expected;
   logic                legal;
   logic                seq_mis;
   logic                err_evt;

   onehot_to_bin #(.WIDTH(WIDTH)) u_enc (
      .vec   (onehot_in),
      .index (index),
      .legal (legal)
   );

   // WIDTH is a power of two, so the natural CODE_W wrap gives 15 -> 0.
   assign expected  = code + CODE_W'(1);
   assign match_inc = match + MATCH_W'(1);
   assign seq_mis   = legal && (state != UNLOCKED) && (index != expected);
   assign err_evt   = in_valid && (!legal || seq_mis);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state      <= UNLOCKED;
         match      <= '0;
         code       <= '0;
         code_valid <= 1'b0;
         onehot_err <= 1'b0;
         seq_err    <= 1'b0;
         locked     <= 1'b0;
      end else begin
         code_valid <= 1'b0;
         onehot_err <= 1'b0;
         seq_err    <= 1'b0;
         if (in_valid) begin
            if (!legal) begin
               onehot_err <= 1'b1;
               state      <= UNLOCKED;
               locked     <= 1'b0;
               match      <= '0;
            end else begin
               code       <= index;
               code_valid <= 1'b1;
               case (state)
                  UNLOCKED: begin
                     state <= ACQUIRE;
                     match <= '0;
                  end
                  ACQUIRE: begin
                     if (seq_mis) begin
                        seq_err <= 1'b1;
                        match   <= '0;
                     end else begin
                        match <= match_inc;
                        if (match_inc == MATCH_W'(LOCK_CNT)) begin
                           state  <= LOCKED;
                           locked <= 1'b1;
                        end
                     end
                  end
                  LOCKED: begin
                     if (seq_mis) begin
                        seq_err <= 1'b1;
                        locked  <= 1'b0;
                        match   <= '0;
                        state   <= ACQUIRE;
                     end
                  end
                  default: begin
                     state  <= UNLOCKED;
                     locked <= 1'b0;
                     match  <= '0;
                  end
               endcase
            end
         end
      end
   end

   // Clear has priority over a simultaneous error.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count <= '0;
      end else if (clr_err) begin
         err_count <= '0;
      end else if (err_evt && (err_count != '1)) begin
         err_count <= err_count + ERR_W'(1);
      end
   end

endmodule
